reg_dma_port: RTL and testbench

REG_DMA_PORT -- requirements
Module: reg_dma_port

---
 rtl/reg_dma_pkg.sv | 7 +
 rtl/reg_dma_ctr.sv | 28 ++
 rtl/reg_dma_port.sv | 114 +++++++++++
 tb/tb_reg_dma_port.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_dma_pkg.sv
// reg_dma_pkg: shared defaults, burst limit and FSM state encoding for the register DMA port
package reg_dma_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int MAX_COUNT = 32;
  typedef enum logic [2:0] {IDLE, RD_FETCH, RD_SEND, WR_RECV, WR_COMMIT, DONE} state_t;
endpackage

// File: rtl/reg_dma_ctr.sv
// reg_dma_ctr: register address (wrapping) and remaining-word count with saturation and last flag
module reg_dma_ctr import reg_dma_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   cnt,
  output logic [AW-1:0] addr,
  output logic [AW:0]   remaining,
  output logic          last
);
  localparam logic [AW:0] SAT = (AW+1)'(MAX_COUNT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      remaining <= '0;
    end else if (load) begin
      addr <= base;
      remaining <= cnt > SAT ? SAT : cnt;
    end else if (inc) begin
      addr <= addr + AW'(1);
      remaining <= remaining - (AW+1)'(1);
    end
  assign last = remaining == (AW+1)'(1);
endmodule

// File: rtl/reg_dma_port.sv
// reg_dma_port: moves bursts of words between a register file and a valid/ready stream pair.
// Every control output is a flop loaded with the value for the state being entered.
module reg_dma_port import reg_dma_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic [AW-1:0]     base_reg,
  input  logic [AW:0]       count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              REG_RD,
  output logic              REG_WR,
  output logic [AW-1:0]     DIR_A,
  output logic [AW-1:0]     DIR_B,
  output logic [AW-1:0]     DIR_WR,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] D0A,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);
  state_t state;
  logic [AW-1:0] addr;
  logic [AW:0] remaining;
  logic last, load, inc, kill;
  assign kill = abort && state != IDLE;
  assign load = state == IDLE && start;
  assign inc = !kill && ((state == RD_SEND && tx_ready) || state == WR_COMMIT);
  reg_dma_ctr #(.AW(AW)) u_ctr (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .inc(inc),
    .base(base_reg),
    .cnt(count),
    .addr(addr),
    .remaining(remaining),
    .last(last)
  );
  assign DIR_A = addr;
  assign DIR_WR = addr;
  assign DIR_B = '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      REG_RD <= 1'b0;
      REG_WR <= 1'b0;
      tx_valid <= 1'b0;
      rx_ready <= 1'b0;
      tx_data <= '0;
      DI <= '0;
    end else begin
      done <= 1'b0;
      REG_RD <= 1'b0;
      REG_WR <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy <= 1'b0;
        tx_valid <= 1'b0;
        rx_ready <= 1'b0;
      end else case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (count == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else if (dir) begin
            state <= WR_RECV;
            rx_ready <= 1'b1;
          end else begin
            state <= RD_FETCH;
            REG_RD <= 1'b1;
          end
        end
        RD_FETCH: begin
          tx_data <= D0A;
          tx_valid <= 1'b1;
          state <= RD_SEND;
        end
        RD_SEND: if (tx_ready) begin
          tx_valid <= 1'b0;
          state <= last ? DONE : RD_FETCH;
          done <= last;
          REG_RD <= !last;
        end
        WR_RECV: if (rx_valid) begin
          DI <= rx_data;
          rx_ready <= 1'b0;
          REG_WR <= 1'b1;
          state <= WR_COMMIT;
        end
        WR_COMMIT: begin
          state <= last ? DONE : WR_RECV;
          done <= last;
          rx_ready <= !last;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_dma_port.sv
// tb_reg_dma_port: directed bursts against reg_dma_port with a behavioural register file and event logs
module tb_reg_dma_port;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 0, rst_n = 0, start = 0, dir = 0, abort = 0, tx_ready = 0, rx_valid = 0;
  logic [AW-1:0] base_reg = '0;
  logic [AW:0] count = '0;
  logic busy, done, REG_RD, REG_WR, tx_valid, rx_ready;
  logic [AW-1:0] DIR_A, DIR_B, DIR_WR;
  logic [DW-1:0] DI, D0A, tx_data;
  logic [DW-1:0] rx_data = '0;
  logic [DW-1:0] regs [32];
  logic [DW-1:0] tx_log [128];
  logic [AW+DW-1:0] wr_log [64];
  int tx_n = 0, wr_n = 0, rd_n = 0, rx_n = 0, done_n = 0, excl_n = 0, cyc = 0, hs_cyc = 0, done_cyc = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign D0A = regs[DIR_A];
  reg_dma_port #(.DATA_W(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .base_reg(base_reg), .count(count),
    .abort(abort), .busy(busy), .done(done), .REG_RD(REG_RD), .REG_WR(REG_WR),
    .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_WR(DIR_WR), .DI(DI), .D0A(D0A),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready) begin
      tx_log[tx_n] <= tx_data;
      tx_n <= tx_n + 1;
      hs_cyc <= cyc;
    end
    if (REG_WR) begin
      wr_log[wr_n] <= {DIR_WR, DI};
      wr_n <= wr_n + 1;
    end
    if (REG_RD) rd_n <= rd_n + 1;
    if (rx_valid && rx_ready) rx_n <= rx_n + 1;
    if (done) begin
      done_n <= done_n + 1;
      done_cyc <= cyc;
    end
    if ((REG_RD && REG_WR) || (tx_valid && rx_ready)) excl_n <= excl_n + 1;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic start_xfer(input logic d, input logic [AW-1:0] b, input logic [AW:0] c);
    dir = d;
    base_reg = b;
    count = c;
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy && i < 300) begin
      tick;
      i++;
    end
    check({tag, " idle"}, busy, 0);
  endtask
  task automatic send_words(input int first, input int n);
    int r0, i;
    for (int k = 0; k < n; k++) begin
      r0 = rx_n;
      i = 0;
      rx_data = DW'(first + k);
      rx_valid = 1;
      while (rx_n == r0 && i < 50) begin
        tick;
        i++;
      end
      check("rx handshake", rx_n - r0, 1);
    end
    rx_valid = 0;
  endtask
  task automatic read_burst(input string tag);
    int t0, r0, d0;
    t0 = tx_n;
    r0 = rd_n;
    d0 = done_n;
    tx_ready = 1;
    start_xfer(0, 8, 3);
    check({tag, " busy"}, busy, 1);
    wait_idle(tag);
    check({tag, " words"}, tx_n - t0, 3);
    check({tag, " w0"}, tx_log[t0], 32'hA);
    check({tag, " w1"}, tx_log[t0+1], 32'hB);
    check({tag, " w2"}, tx_log[t0+2], 32'hC);
    check({tag, " reads"}, rd_n - r0, 3);
    check({tag, " done cnt"}, done_n - d0, 1);
    check({tag, " done lag"}, done_cyc - hs_cyc, 1);
  endtask
  initial begin
    int t0, r0, w0, d0, i, bad;
    for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? '0 : 32'h1000 + k;
    regs[8] = 32'hA;
    regs[9] = 32'hB;
    regs[10] = 32'hC;
    regs[12] = 32'h11;
    regs[13] = 32'h22;
    regs[14] = 32'h33;
    repeat (3) tick;
    check("reset ctrl", {busy, done, REG_RD, REG_WR, tx_valid, rx_ready}, 0);
    check("reset data", {tx_data, DI}, 0);
    check("reset addr", {DIR_A, DIR_WR, DIR_B}, 0);
    rst_n = 1;
    tick;
    read_burst("rd");
    // stall the second word for five cycles
    t0 = tx_n;
    r0 = rd_n;
    start_xfer(0, 12, 3);
    i = 0;
    while (!(tx_valid && tx_n - t0 == 1) && i < 50) begin
      tick;
      i++;
    end
    tx_ready = 0;
    repeat (5) begin
      tick;
      check("bp data", tx_data, 32'h22);
    end
    check("bp valid", tx_valid, 1);
    check("bp reads", rd_n - r0, 2);
    tx_ready = 1;
    wait_idle("bp");
    check("bp w0", tx_log[t0], 32'h11);
    check("bp w1", tx_log[t0+1], 32'h22);
    check("bp w2", tx_log[t0+2], 32'h33);
    check("bp reads end", rd_n - r0, 3);
    w0 = wr_n;
    d0 = done_n;
    start_xfer(1, 30, 4);
    send_words(1, 4);
    wait_idle("wr");
    check("wr count", wr_n - w0, 4);
    check("wr0", wr_log[w0], {5'd30, 32'd1});
    check("wr1", wr_log[w0+1], {5'd31, 32'd2});
    check("wr2", wr_log[w0+2], {5'd0, 32'd3});
    check("wr3", wr_log[w0+3], {5'd1, 32'd4});
    check("wr done", done_n - d0, 1);
    r0 = rd_n;
    w0 = wr_n;
    start_xfer(0, 3, 0);
    check("cnt0 done", {done, busy}, 2'b11);
    tick;
    check("cnt0 end", {done, busy}, 0);
    check("cnt0 access", (rd_n - r0) + (wr_n - w0), 0);
    t0 = tx_n;
    r0 = rd_n;
    start_xfer(0, 0, 40);
    wait_idle("sat");
    check("sat words", tx_n - t0, 32);
    check("sat reads", rd_n - r0, 32);
    bad = 0;
    for (int k = 0; k < 32; k++) if (tx_log[t0+k] !== regs[k]) bad++;
    check("sat data", bad, 0);
    w0 = wr_n;
    d0 = done_n;
    start_xfer(1, 4, 5);
    send_words(7, 2);
    tick;
    check("ab recv", rx_ready, 1);
    dir = 0;
    base_reg = 8;
    count = 3;
    start = 1;
    tick;
    start = 0;
    check("start ignored", {busy, rx_ready, REG_RD}, 3'b110);
    abort = 1;
    rx_valid = 1;
    rx_data = 32'h99;
    tick;
    abort = 0;
    rx_valid = 0;
    check("abort outs", {busy, rx_ready, REG_WR, tx_valid, REG_RD}, 0);
    repeat (4) tick;
    check("abort writes", wr_n - w0, 2);
    check("abort done", done_n - d0, 0);
    // async reset while a word waits in RD_SEND
    w0 = wr_n;
    d0 = done_n;
    tx_ready = 0;
    start_xfer(0, 8, 3);
    tick;
    check("rst pre", tx_valid, 1);
    #2 rst_n = 0;
    #1;
    check("rst ctrl", {busy, done, REG_RD, REG_WR, tx_valid, rx_ready}, 0);
    check("rst data", {tx_data, DI, DIR_A, DIR_WR}, 0);
    tick;
    rst_n = 1;
    repeat (3) tick;
    check("rst after", {busy, done_n - d0, wr_n - w0}, 0);
    read_burst("rd2");
    check("exclusive", excl_n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
